muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It accepts one M-extension operation at a time and computes it over multiple cycles. While working it drives the pipeline stall request that the hazard unit converts into `stall_execute`. It delivers a one-cycle result strobe to the execute/memory boundary and honours `flush_execute`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  valid M-extension op present in execute this cycle
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rs1_data`  in  32  forwarded rs1 operand
- `rs2_data`  in  32  forwarded rs2 operand
- `flush`  in  1  abort the in-flight op (from `flush_execute`)
- `busy`  out  1  stall request to the hazard unit (OR-ed into `stall_execute`)
- `result_valid`  out  1  one-cycle strobe, `result` is valid
- `result`  out  32  rd write data

## Operation
- FSM states: IDLE, CALC, DONE. Reset enters IDLE asynchronously, clears the counter and all registers, and drives `busy`=0, `result_valid`=0, `result`=0.
- IDLE with `start`=1 and `flush`=0:
  - Latch the op.
  - Latch |rs1| and |rs2| according to signedness. MULH, DIV and REM treat both operands as signed. MULHSU treats only rs1 as signed. MULHU, DIVU and REMU are unsigned.
  - Latch the result sign. Product and quotient sign = sign1 XOR sign2. Remainder sign = sign1.
  - Load the counter with 31.
  - Go to CALC, or go to DONE for an early-out case.
- Early-out cases go IDLE→DONE directly:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, using a 33-bit partial remainder.
- CALC when counter = 0: apply the sign correction (two's-complement negate), select the result, and go to DONE.
  - MUL selects the low 32 bits of the product.
  - MULH, MULHSU and MULHU select the high 32 bits.
  - DIV and DIVU select the quotient.
  - REM and REMU select the remainder.
- DONE: `result_valid`=1 and `busy`=0, so the pipeline advances. `start` is ignored in this cycle because it is the same instruction. Next state is IDLE.
- `busy` = (IDLE & `start` & !`flush`) | CALC. It is combinational from `start` so the stall appears in the instruction's first execute cycle.
- `flush` has priority in every state: the next state is IDLE, the op is discarded, and no `result_valid` is produced. A flush during DONE does not suppress the current-cycle strobe. Downstream flush logic kills it.
- Reset asserted mid-operation aborts immediately. No partial result is ever emitted.

## Timing
- Start cycle is T0.
- Iterative path: `busy`=1 during T0..T32, CALC runs T1..T32, DONE is at T33 with `result_valid`=1.
- Early-out path: `busy`=1 at T0, `result_valid`=1 at T1.
- Back-to-back ops: the next `start` is accepted in the cycle after DONE, with a minimum gap of 0 idle cycles between DONE and the next T0.
- `result` holds its last value outside DONE. Consumers must qualify it with `result_valid`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL, MULH, MULHSU and MULHU compute a single-cycle 33×33 signed product in IDLE and take the early-out path (`busy` at T0, result at T1).
  - Division stays iterative.
- Undefined: all eight ops use the 32-iteration path described above.

## Structure
- `cpu_defs.vh` holds the `MD_*` funct3 encodings, the `MD_ST_IDLE/CALC/DONE` state encodings and `MD_ITER = 31`.
- One sub-module, `muldiv_step`, is the combinational single-iteration datapath for a shift-add or restoring-subtract step, selected by an is_div input. The FSM, counter and sign handling stay in `muldiv_unit`.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `result` = 0xFFFFFFEB at T33; `busy` high T0..T32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 0x80000000 / 3 → 0x2AAAAAAA.
- DIV x / 0 → 0xFFFFFFFF at T1, and REMU 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000 and REM → 0, both at T1.
- `flush` asserted at T10 of a DIV → IDLE at T11, no `result_valid`; a new `start` at T11 completes normally.
- `reset` low at T5 → immediate IDLE with all outputs 0; DONE with `start` held does not restart the op.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: funct3 encodings, FSM states and iteration count shared by the multiply/divide unit
package muldiv_unit_pkg;
  typedef enum logic [1:0] {MD_ST_IDLE, MD_ST_CALC, MD_ST_DONE} md_state_e;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;
  localparam logic [4:0] MD_ITER = 5'd31;
endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_unit_step: one shift-add (multiply) or restoring-subtract (divide) iteration on {hi,lo}
module muldiv_unit_step (
  input  logic        i_is_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_b,
  output logic [63:0] o_acc
);
  logic [32:0] w_sum, w_shift;
  logic [31:0] w_diff;
  logic        w_ge;
  always_comb begin
    w_sum   = {1'b0, i_acc[63:32]} + {1'b0, i_acc[0] ? i_b : 32'h0};
    w_shift = {i_acc[63:32], i_acc[31]};
    w_ge    = w_shift >= {1'b0, i_b};
    // the true difference is below the divisor, so 32 bits hold it exactly
    w_diff  = w_shift[31:0] - i_b;
    o_acc   = !i_is_div ? {w_sum, i_acc[31:1]} :
              w_ge ? {w_diff, i_acc[30:0], 1'b1} : {w_shift[31:0], i_acc[30:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide; MULDIV_FAST_MUL_EN makes multiplies single-cycle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_result_valid,
  output logic [XLEN-1:0] o_result
);
  md_state_e   r_state, w_state_n;
  md_op_e      r_op;
  logic [63:0] r_acc, w_step, w_mag, w_signed;
  logic [31:0] r_b, r_result, w_abs1, w_abs2, w_div_early, w_early_res, w_final;
  logic [4:0]  r_cnt;
  logic        r_neg, w_s1, w_s2, w_neg, w_dz, w_ovf, w_early, w_accept;

  muldiv_unit_step u_step (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_b      (r_b),
    .o_acc    (w_step)
  );

  always_comb begin
    w_s1        = (i_op == MD_MULH || i_op == MD_MULHSU || i_op == MD_DIV || i_op == MD_REM) && i_rs1_data[31];
    w_s2        = (i_op == MD_MULH || i_op == MD_DIV || i_op == MD_REM) && i_rs2_data[31];
    w_abs1      = w_s1 ? -i_rs1_data : i_rs1_data;
    w_abs2      = w_s2 ? -i_rs2_data : i_rs2_data;
    w_neg       = (i_op == MD_REM) ? w_s1 : w_s1 ^ w_s2;
    w_dz        = i_op[2] && i_rs2_data == 32'h0;
    w_ovf       = (i_op == MD_DIV || i_op == MD_REM) && i_rs1_data == 32'h8000_0000 && i_rs2_data == 32'hFFFF_FFFF;
    w_div_early = w_dz ? (i_op[1] ? i_rs1_data : 32'hFFFF_FFFF) : (i_op[1] ? 32'h0 : 32'h8000_0000);
    w_accept    = r_state == MD_ST_IDLE && i_start && !i_flush;
    w_mag       = !r_op[2] ? w_step : {32'h0, r_op[1] ? w_step[63:32] : w_step[31:0]};
    w_signed    = r_neg ? -w_mag : w_mag;
    w_final     = (r_op == MD_MUL || r_op[2]) ? w_signed[31:0] : w_signed[63:32];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_prod;
  assign w_prod      = 64'($signed({w_s1, i_rs1_data}) * $signed({w_s2, i_rs2_data}));
  assign w_early     = w_dz || w_ovf || !i_op[2];
  assign w_early_res = i_op[2] ? w_div_early : (i_op == MD_MUL) ? w_prod[31:0] : w_prod[63:32];
`else
  assign w_early     = w_dz || w_ovf;
  assign w_early_res = w_div_early;
`endif

  always_comb begin
    w_state_n      = i_flush ? MD_ST_IDLE :
                     (r_state == MD_ST_IDLE) ? (i_start ? (w_early ? MD_ST_DONE : MD_ST_CALC) : MD_ST_IDLE) :
                     (r_state == MD_ST_CALC) ? (r_cnt == 5'd0 ? MD_ST_DONE : MD_ST_CALC) : MD_ST_IDLE;
    o_busy         = w_accept || r_state == MD_ST_CALC;
    o_result_valid = r_state == MD_ST_DONE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_state <= MD_ST_IDLE;
    else r_state <= w_state_n;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_op     <= MD_MUL;
      r_acc    <= 64'h0;
      r_b      <= 32'h0;
      r_neg    <= 1'b0;
      r_cnt    <= 5'd0;
      r_result <= 32'h0;
    end else if (w_accept) begin
      r_op  <= md_op_e'(i_op);
      r_acc <= {32'h0, w_abs1};
      r_b   <= w_abs2;
      r_neg <= w_neg;
      r_cnt <= MD_ITER;
      if (w_early) r_result <= w_early_res;
    end else if (r_state == MD_ST_CALC && !i_flush) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd0) r_result <= w_final;
    end

  assign o_result = r_result;
endmodule
